// File: rtl/par2ser_nw_pkg.sv
// Shared word-order constants and elaboration helpers for the N-word parallel-to-serial converter.
package par2ser_nw_pkg;

  localparam int unsigned P2S_MSB_FIRST = 0;
  localparam int unsigned P2S_LSB_FIRST = 1;

  // Smallest r with 2**r >= n; sizes the word index.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/p2s_slot.sv
// Single-entry register with a valid flag; load takes priority over clear.
module p2s_slot #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [0:W-1] din,
  output logic [0:W-1] dout,
  output logic         valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/par2ser_nw.sv
// Parallel-to-serial converter: one NWORDS-word group in, NWORDS words out, with a
// holding slot that refills while the current group drains so groups run back to back.
module par2ser_nw
  import par2ser_nw_pkg::*;
#(
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned NWORDS    = 2,
  parameter int unsigned LSB_FIRST = P2S_MSB_FIRST
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       req_in,
  input  logic                       ack_in,
  input  logic [0:DWIDTH*NWORDS-1]   data_in,
  output logic                       req_out,
  input  logic                       ack_out,
  output logic [0:DWIDTH-1]          data_out,
  output logic                       last_out
);

  localparam int unsigned DDWIDTH = DWIDTH * NWORDS;
  localparam int unsigned IDXW    = clog2(NWORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  if (NWORDS < 2 || NWORDS > 16) begin : g_bad_nwords
    $error("par2ser_nw: NWORDS must be in 2..16");
  end

  logic [0:DDWIDTH-1] hb_data;
  logic               hb_valid;
  logic [0:DDWIDTH-1] ob, ob_n;
  logic               ob_valid, ob_valid_n;
  logic [IDXW-1:0]    idx, idx_n, sel_n;
  logic [0:DWIDTH-1]  word_n;
  logic               hb_load, out_xfer, group_done, move, hb_valid_n;

  p2s_slot #(.W(DDWIDTH)) u_hb (
    .clk   (clk),
    .rst   (rst),
    .load  (hb_load),
    .clear (move),
    .din   (data_in),
    .dout  (hb_data),
    .valid (hb_valid)
  );

  // Handshake decode and next state of the output buffer.
  always_comb begin
    hb_load    = req_in && ack_in;
    out_xfer   = ob_valid && ack_out;
    group_done = out_xfer && (idx == LAST_IDX);
    move       = hb_valid && (!ob_valid || group_done);
    hb_valid_n = hb_load || (hb_valid && !move);

    ob_n       = ob;
    ob_valid_n = ob_valid;
    idx_n      = idx;
    if (move) begin
      ob_n       = hb_data;
      ob_valid_n = 1'b1;
      idx_n      = '0;
    end else if (group_done) begin
      ob_valid_n = 1'b0;
      idx_n      = '0;
    end else if (out_xfer) begin
      idx_n = idx + IDXW'(1);
    end

    sel_n  = (LSB_FIRST == P2S_LSB_FIRST) ? (LAST_IDX - idx_n) : idx_n;
    word_n = '0;
    for (int unsigned k = 0; k < NWORDS; k++) begin
      if (sel_n == IDXW'(k)) word_n = ob_n[k*DWIDTH +: DWIDTH];
    end
  end

  // Outputs are registered from the next state so they line up with ob/idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      ob       <= '0;
      ob_valid <= 1'b0;
      idx      <= '0;
      req_in   <= 1'b0;
      req_out  <= 1'b0;
      last_out <= 1'b0;
      data_out <= '0;
    end else begin
      ob       <= ob_n;
      ob_valid <= ob_valid_n;
      idx      <= idx_n;
      req_in   <= !hb_valid_n;
      req_out  <= ob_valid_n;
      last_out <= ob_valid_n && (idx_n == LAST_IDX);
      data_out <= word_n;
    end
  end

endmodule

// File: tb/tb_par2ser_nw.sv
// Self-checking bench: three converter configurations, directed tables/sequences and a random run.
module tb_par2ser_nw;

  localparam logic [1:0] DA = 2'd0;  // DWIDTH=16, NWORDS=2, MSB first
  localparam logic [1:0] DB = 2'd1;  // DWIDTH=16, NWORDS=2, LSB first
  localparam logic [1:0] DC = 2'd2;  // DWIDTH=8,  NWORDS=4, MSB first
  localparam int NR = 30;

  typedef struct packed {
    logic [15:0] w;
    logic        last;
    logic [31:0] cyc;
  } rec_t;

  typedef struct {
    logic [31:0] grp;
    logic [15:0] m0, m1, l0, l1;
  } vec_t;

  logic        clk;
  logic [2:0]  rst_v, ack_in_v, ack_out_v;
  logic [2:0]  req_in_v, req_out_v, last_v;
  logic [0:31] din_a, din_b, din_c;
  logic [0:15] dout_a, dout_b;
  logic [0:7]  dout_c;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  rec_t        obs0[$], obs1[$], obs2[$];

  par2ser_nw #(.DWIDTH(16), .NWORDS(2), .LSB_FIRST(0)) dut_a (
    .clk(clk), .rst(rst_v[0]), .req_in(req_in_v[0]), .ack_in(ack_in_v[0]), .data_in(din_a),
    .req_out(req_out_v[0]), .ack_out(ack_out_v[0]), .data_out(dout_a), .last_out(last_v[0]));
  par2ser_nw #(.DWIDTH(16), .NWORDS(2), .LSB_FIRST(1)) dut_b (
    .clk(clk), .rst(rst_v[1]), .req_in(req_in_v[1]), .ack_in(ack_in_v[1]), .data_in(din_b),
    .req_out(req_out_v[1]), .ack_out(ack_out_v[1]), .data_out(dout_b), .last_out(last_v[1]));
  par2ser_nw #(.DWIDTH(8), .NWORDS(4), .LSB_FIRST(0)) dut_c (
    .clk(clk), .rst(rst_v[2]), .req_in(req_in_v[2]), .ack_in(ack_in_v[2]), .data_in(din_c),
    .req_out(req_out_v[2]), .ack_out(ack_out_v[2]), .data_out(dout_c), .last_out(last_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t mk_rec(logic [15:0] w, logic l, int c);
    rec_t r;
    r.w = w; r.last = l; r.cyc = 32'(c);
    return r;
  endfunction

  // Record every output transfer that the coming edge will perform.
  always @(negedge clk) begin
    if (!rst_v[0] && req_out_v[0] && ack_out_v[0]) obs0.push_back(mk_rec(16'(dout_a), last_v[0], cyc));
    if (!rst_v[1] && req_out_v[1] && ack_out_v[1]) obs1.push_back(mk_rec(16'(dout_b), last_v[1], cyc));
    if (!rst_v[2] && req_out_v[2] && ack_out_v[2]) obs2.push_back(mk_rec({8'h00, dout_c}, last_v[2], cyc));
  end

  function automatic int obs_size(logic [1:0] d);
    case (d)
      DA: return obs0.size();
      DB: return obs1.size();
      default: return obs2.size();
    endcase
  endfunction

  function automatic rec_t obs_at(logic [1:0] d, int i);
    rec_t r;
    r = '0;
    if (i < obs_size(d)) begin
      case (d)
        DA: r = obs0[i];
        DB: r = obs1[i];
        default: r = obs2[i];
      endcase
    end
    return r;
  endfunction

  function automatic logic [15:0] get_dout(logic [1:0] d);
    case (d)
      DA: return 16'(dout_a);
      DB: return 16'(dout_b);
      default: return {8'h00, dout_c};
    endcase
  endfunction

  // Reference: word k of a group as emitted, from the word-order rule alone.
  function automatic logic [15:0] exp_word(logic [31:0] g, int n, int dw, bit lsb, int k);
    int w;
    logic [31:0] m;
    w = lsb ? (n - 1 - k) : k;
    m = (32'd1 << dw) - 32'd1;
    return 16'((g >> ((n - 1 - w) * dw)) & m);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr(logic [1:0] d);
    case (d)
      DA: obs0.delete();
      DB: obs1.delete();
      default: obs2.delete();
    endcase
  endtask

  task automatic set_din(logic [1:0] d, logic [31:0] g);
    case (d)
      DA: din_a = g;
      DB: din_b = g;
      default: din_c = g;
    endcase
  endtask

  // Offer one group and hold ack_in until the block takes it (bounded).
  task automatic send(logic [1:0] d, logic [31:0] g);
    bit got;
    got = 1'b0;
    set_din(d, g);
    ack_in_v[d] = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_in_v[d]) got = 1'b1;
      tick();
    end
    ack_in_v[d] = 1'b0;
    chk($sformatf("send%0d_accepted", d), 32'(got), 32'd1);
  endtask

  task automatic wait_words(logic [1:0] d, int n);
    int i;
    i = 0;
    while (obs_size(d) < n && i < 60) begin
      tick();
      i++;
    end
    chk($sformatf("words%0d_reach_%0d", d, n), 32'(obs_size(d) >= n), 32'd1);
  endtask

  initial begin
    vec_t        tbl[4];
    logic [7:0]  exp12[12];
    logic [31:0] sent_b[$], sent_c[$];
    rec_t        r;
    bit          xb, xc;

    tbl[0] = '{32'hAAAA5555, 16'hAAAA, 16'h5555, 16'h5555, 16'hAAAA};
    tbl[1] = '{32'h12345678, 16'h1234, 16'h5678, 16'h5678, 16'h1234};
    tbl[2] = '{32'hFFFF0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
    tbl[3] = '{32'h0001FFFE, 16'h0001, 16'hFFFE, 16'hFFFE, 16'h0001};
    exp12  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

    rst_v = 3'b111; ack_in_v = '0; ack_out_v = '0;
    din_a = '0; din_b = '0; din_c = '0;

    // Reset state and req_in rising one edge after release.
    repeat (3) tick();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_req_in%0d", d), 32'(req_in_v[d]), 32'd0);
      chk($sformatf("rst_req_out%0d", d), 32'(req_out_v[d]), 32'd0);
      chk($sformatf("rst_last%0d", d), 32'(last_v[d]), 32'd0);
    end
    tick();
    rst_v = 3'b000;
    @(negedge clk);
    chk("req_in_before_first_edge", 32'(req_in_v), 32'd0);
    tick();
    @(negedge clk);
    chk("req_in_after_release", 32'(req_in_v), 32'h7);
    chk("req_out_idle", 32'(req_out_v), 32'd0);
    tick();

    // Latency: accept at T, OB loaded at T+1, first word visible after T+1.
    din_a = 32'hAAAA5555; ack_in_v[0] = 1'b1; ack_out_v[0] = 1'b1;
    @(negedge clk);
    chk("lat_req_in", 32'(req_in_v[0]), 32'd1);
    tick();
    ack_in_v[0] = 1'b0;
    @(negedge clk);
    chk("lat_not_yet", 32'(req_out_v[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("lat_w0_req", 32'(req_out_v[0]), 32'd1);
    chk("lat_w0_data", 32'(get_dout(DA)), 32'hAAAA);
    chk("lat_w0_last", 32'(last_v[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("lat_w1_data", 32'(get_dout(DA)), 32'h5555);
    chk("lat_w1_last", 32'(last_v[0]), 32'd1);
    tick();
    @(negedge clk);
    chk("lat_done_req", 32'(req_out_v[0]), 32'd0);
    chk("lat_done_last", 32'(last_v[0]), 32'd0);
    tick();

    // Word-order table on both 2-word configurations.
    ack_out_v[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clr(DA); clr(DB);
      send(DA, tbl[i].grp);
      send(DB, tbl[i].grp);
      wait_words(DA, 2);
      wait_words(DB, 2);
      r = obs_at(DA, 0); chk($sformatf("tbl%0d_msb_w0", i), 32'(r.w), 32'(tbl[i].m0));
      chk($sformatf("tbl%0d_msb_l0", i), 32'(r.last), 32'd0);
      r = obs_at(DA, 1); chk($sformatf("tbl%0d_msb_w1", i), 32'(r.w), 32'(tbl[i].m1));
      chk($sformatf("tbl%0d_msb_l1", i), 32'(r.last), 32'd1);
      r = obs_at(DB, 0); chk($sformatf("tbl%0d_lsb_w0", i), 32'(r.w), 32'(tbl[i].l0));
      chk($sformatf("tbl%0d_lsb_l0", i), 32'(r.last), 32'd0);
      r = obs_at(DB, 1); chk($sformatf("tbl%0d_lsb_w1", i), 32'(r.w), 32'(tbl[i].l1));
      chk($sformatf("tbl%0d_lsb_l1", i), 32'(r.last), 32'd1);
    end

    // Three groups back to back on the 4-word block: 12 words on consecutive cycles.
    clr(DC);
    ack_out_v[2] = 1'b1;
    send(DC, 32'h11223344);
    send(DC, 32'h55667788);
    send(DC, 32'h99AABBCC);
    wait_words(DC, 12);
    repeat (3) tick();
    chk("b2b_count", 32'(obs_size(DC)), 32'd12);
    for (int i = 0; i < 12; i++) begin
      r = obs_at(DC, i);
      chk($sformatf("b2b_w%0d", i), 32'(r.w), 32'(exp12[i]));
      chk($sformatf("b2b_last%0d", i), 32'(r.last), 32'((i % 4) == 3));
      chk($sformatf("b2b_cyc%0d", i), r.cyc - obs_at(DC, 0).cyc, 32'(i));
    end

    // Backpressure while 0x22 is shown, with the next group parked in HB.
    clr(DC);
    ack_out_v[2] = 1'b0;
    send(DC, 32'h11223344);
    send(DC, 32'h55667788);
    ack_out_v[2] = 1'b1;
    tick();
    ack_out_v[2] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(get_dout(DC)), 32'h22);
      chk("bp_hold_req", 32'(req_out_v[2]), 32'd1);
      chk("bp_hold_last", 32'(last_v[2]), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("bp_req_in_low", 32'(req_in_v[2]), 32'd0);
    tick();
    ack_out_v[2] = 1'b1;
    wait_words(DC, 8);
    repeat (3) tick();
    chk("bp_count", 32'(obs_size(DC)), 32'd8);
    for (int i = 0; i < 8; i++) begin
      r = obs_at(DC, i);
      chk($sformatf("bp_w%0d", i), 32'(r.w), 32'(exp12[i]));
      chk($sformatf("bp_last%0d", i), 32'(r.last), 32'((i % 4) == 3));
    end

    // Reset in the middle of a group with HB full, then a clean new group.
    clr(DA);
    ack_out_v[0] = 1'b0;
    send(DA, 32'hCAFEF00D);
    send(DA, 32'h13572468);
    ack_out_v[0] = 1'b1;
    tick();
    ack_out_v[0] = 1'b0;
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    clr(DA);
    @(negedge clk);
    chk("mrst_req_out", 32'(req_out_v[0]), 32'd0);
    chk("mrst_last", 32'(last_v[0]), 32'd0);
    chk("mrst_req_in", 32'(req_in_v[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("mrst_req_in_rise", 32'(req_in_v[0]), 32'd1);
    tick();
    ack_out_v[0] = 1'b1;
    repeat (4) tick();
    chk("mrst_no_stale", 32'(obs_size(DA)), 32'd0);
    send(DA, 32'hDEADBEEF);
    wait_words(DA, 2);
    repeat (4) tick();
    chk("mrst_count", 32'(obs_size(DA)), 32'd2);
    r = obs_at(DA, 0); chk("mrst_w0", 32'(r.w), 32'hDEAD);
    r = obs_at(DA, 1); chk("mrst_w1", 32'(r.w), 32'hBEEF);
    chk("mrst_l1", 32'(r.last), 32'd1);

    // Slow producer on the LSB-first block; ack_out stays high throughout.
    clr(DB);
    ack_out_v[1] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("slow_idle_req_out", 32'(req_out_v[1]), 32'd0);
      tick();
    end
    send(DB, 32'hA1B2C3D4);
    wait_words(DB, 2);
    repeat (6) begin
      @(negedge clk);
      chk("slow_gap_req_out", 32'(req_out_v[1]), 32'd0);
      tick();
    end
    send(DB, 32'h0F1E2D3C);
    wait_words(DB, 4);
    repeat (3) tick();
    chk("slow_count", 32'(obs_size(DB)), 32'd4);
    r = obs_at(DB, 0); chk("slow_w0", 32'(r.w), 32'hC3D4);
    r = obs_at(DB, 1); chk("slow_w1", 32'(r.w), 32'hA1B2);
    chk("slow_l1", 32'(r.last), 32'd1);
    r = obs_at(DB, 2); chk("slow_w2", 32'(r.w), 32'h2D3C);
    r = obs_at(DB, 3); chk("slow_w3", 32'(r.w), 32'h0F1E);
    chk("slow_gap", 32'(obs_at(DB, 2).cyc - obs_at(DB, 1).cyc > 32'd1), 32'd1);

    // Random producer/consumer on DB and DC against the word-order reference.
    clr(DB); clr(DC);
    ack_in_v[1] = 1'b0; ack_in_v[2] = 1'b0;
    for (int c = 0; c < 3000 && !(obs_size(DB) >= 2 * NR && obs_size(DC) >= 4 * NR); c++) begin
      @(negedge clk);
      xb = req_in_v[1] && ack_in_v[1];
      xc = req_in_v[2] && ack_in_v[2];
      if (xb) sent_b.push_back(din_b);
      if (xc) sent_c.push_back(din_c);
      tick();
      if (!ack_in_v[1] || xb) begin
        ack_in_v[1] = (sent_b.size() < NR) && ($urandom_range(0, 2) != 0);
        din_b = $urandom;
      end
      if (!ack_in_v[2] || xc) begin
        ack_in_v[2] = (sent_c.size() < NR) && ($urandom_range(0, 2) != 0);
        din_c = $urandom;
      end
      ack_out_v[1] = ($urandom_range(0, 3) != 0);
      ack_out_v[2] = ($urandom_range(0, 3) != 0);
    end
    ack_in_v = '0;
    chk("rnd_b_count", 32'(obs_size(DB)), 32'(2 * NR));
    chk("rnd_c_count", 32'(obs_size(DC)), 32'(4 * NR));
    for (int i = 0; i < obs_size(DB) && i / 2 < sent_b.size(); i++) begin
      r = obs_at(DB, i);
      chk($sformatf("rnd_b_w%0d", i), 32'(r.w), 32'(exp_word(sent_b[i / 2], 2, 16, 1'b1, i % 2)));
      chk($sformatf("rnd_b_l%0d", i), 32'(r.last), 32'((i % 2) == 1));
    end
    for (int i = 0; i < obs_size(DC) && i / 4 < sent_c.size(); i++) begin
      r = obs_at(DC, i);
      chk($sformatf("rnd_c_w%0d", i), 32'(r.w), 32'(exp_word(sent_c[i / 4], 4, 8, 1'b0, i % 4)));
      chk($sformatf("rnd_c_l%0d", i), 32'(r.last), 32'((i % 4) == 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
